// File: rtl/softmax_row_sequencer.sv
// Three-pass softmax row controller: running-max sweep, exponent-accumulate sweep,
// then a flow-controlled normalise sweep presented on a valid/ready output stream.
module softmax_row_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [LEN_W-1:0] row_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LEN_W-1:0] rd_addr,
    output logic             dp_clr,
    output logic             en_max,
    output logic             en_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_MAX   = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_MAX  = 2'd1;
    localparam logic [1:0] TAG_ACC  = 2'd2;

    localparam logic [LEN_W-1:0] ADDR_ZERO = '0;
    localparam logic [LEN_W-1:0] ADDR_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic [1:0]       tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [LEN_W-1:0] out_idx_q, out_idx_d;

    logic slot_free;
    logic last_addr;
    logic rd_en_c;
    logic rd_norm;

    // The output slot frees up in the same cycle the presented result is taken,
    // which is what lets NORM reads run without bubbles under a steady ready.
    assign slot_free = !out_valid_q || out_ready;
    assign last_addr = (addr_q == (len_q - ADDR_ONE));
    assign rd_norm   = (state_q == S_NORM) && slot_free;

    always_comb begin
        rd_en_c = 1'b0;
        case (state_q)
            S_MAX, S_ACC: rd_en_c = 1'b1;
            S_NORM:       rd_en_c = slot_free;
            default:      rd_en_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_len != ADDR_ZERO) begin
                        len_d   = row_len;
                        state_d = S_CLR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLR: begin
                addr_d  = ADDR_ZERO;
                state_d = S_MAX;
            end
            S_MAX: begin
                if (last_addr) begin
                    addr_d  = ADDR_ZERO;
                    state_d = S_ACC;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_ACC: begin
                if (last_addr) begin
                    addr_d  = ADDR_ZERO;
                    state_d = S_NORM;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_NORM: begin
                if (rd_norm) begin
                    if (last_addr) begin
                        addr_d  = ADDR_ZERO;
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (slot_free) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_d = S_IDLE;
            addr_d  = ADDR_ZERO;
        end
    end

    always_comb begin
        tag_d       = TAG_NONE;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (rd_en_c && (state_q == S_MAX)) begin
            tag_d = TAG_MAX;
        end else if (rd_en_c && (state_q == S_ACC)) begin
            tag_d = TAG_ACC;
        end
        if (rd_norm) begin
            out_valid_d = 1'b1;
            out_idx_d   = addr_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (abort) begin
            tag_d       = TAG_NONE;
            out_valid_d = 1'b0;
            out_idx_d   = ADDR_ZERO;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            len_q       <= ADDR_ZERO;
            addr_q      <= ADDR_ZERO;
            tag_q       <= TAG_NONE;
            out_valid_q <= 1'b0;
            out_idx_q   <= ADDR_ZERO;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dp_clr    = (state_q == S_CLR);
    assign rd_en     = rd_en_c;
    assign rd_addr   = addr_q;
    assign en_max    = (tag_q == TAG_MAX);
    assign en_acc    = (tag_q == TAG_ACC);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_softmax_row_sequencer.sv
// Scenario bench for softmax_row_sequencer: fixed schedules plus random rows with
// random backpressure, checked against a cycle schedule derived from the row rules.
module tb_softmax_row_sequencer;

    localparam int LEN_W = 8;
    localparam int MAXC  = 1024;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] row_len = '0;
    logic             abort = 1'b0;
    logic             busy, done, rd_en, dp_clr, en_max, en_acc, out_valid;
    logic [LEN_W-1:0] rd_addr, out_idx;
    logic             out_ready = 1'b1;

    int checks;
    int errors;

    logic tr_busy [MAXC];
    logic tr_done [MAXC];
    logic tr_rd   [MAXC];
    logic tr_clr  [MAXC];
    logic tr_mx   [MAXC];
    logic tr_ac   [MAXC];
    logic tr_ov   [MAXC];
    logic [LEN_W-1:0] tr_addr [MAXC];
    logic [LEN_W-1:0] tr_idx  [MAXC];
    logic rdy_pat [MAXC];
    int   ncyc;
    int   abort_at, rst_at, xs_at;
    logic [LEN_W-1:0] xs_len;

    // expected schedule for the random-row scenario
    logic e_bz [MAXC];
    logic e_dn [MAXC];
    logic e_rd [MAXC];
    logic e_cl [MAXC];
    logic e_mx [MAXC];
    logic e_ac [MAXC];
    logic e_ov [MAXC];
    int   e_addr [MAXC];
    int   e_idx  [MAXC];

    softmax_row_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .row_len(row_len), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .dp_clr(dp_clr),
        .en_max(en_max), .en_acc(en_acc), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx)
    );

    always #5 CLK = ~CLK;

    task automatic set_defaults();
        for (int i = 0; i < MAXC; i++) rdy_pat[i] = 1'b1;
        abort_at = -1;
        rst_at   = -1;
        xs_at    = -1;
        xs_len   = '0;
    endtask

    task automatic sample(input int c);
        tr_busy[c] = busy;   tr_done[c] = done;   tr_rd[c] = rd_en;
        tr_clr[c]  = dp_clr; tr_mx[c]   = en_max; tr_ac[c] = en_acc;
        tr_ov[c]   = out_valid; tr_addr[c] = rd_addr; tr_idx[c] = out_idx;
    endtask

    // Cycle 0 is the cycle in which start is presented; stops two cycles after done or at lim.
    task automatic run_row(input int n, input int lim);
        int done_c;
        done_c = -1;
        for (int i = 0; i < MAXC; i++) begin
            tr_busy[i] = 0; tr_done[i] = 0; tr_rd[i] = 0; tr_clr[i] = 0; tr_mx[i] = 0;
            tr_ac[i] = 0; tr_ov[i] = 0; tr_addr[i] = '0; tr_idx[i] = '0;
        end
        @(negedge CLK);
        start = 1'b1; row_len = n[LEN_W-1:0]; abort = 1'b0; RST_n = 1'b1; out_ready = rdy_pat[0];
        #1 sample(0);
        ncyc = 1;
        for (int c = 1; c < lim && c < MAXC; c++) begin
            @(negedge CLK);
            start = (c == xs_at);
            if (c == xs_at) row_len = xs_len;
            abort = (c == abort_at);
            RST_n = !(c == rst_at);
            out_ready = rdy_pat[c];
            #1 sample(c);
            ncyc = c + 1;
            if (tr_done[c] && done_c < 0) done_c = c;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        start = 1'b0; abort = 1'b0; RST_n = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if ({busy, done, rd_en, dp_clr, en_max, en_acc, out_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes: got busy/done/rd/clr/max/acc/ov=%b required 0000000",
                     {busy, done, rd_en, dp_clr, en_max, en_acc, out_valid});
        end
        checks++;
        if (rd_addr !== 8'd0 || out_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr: got rd_addr=%0d out_idx=%0d required 0 0", rd_addr, out_idx);
        end
        RST_n = 1'b1;
        @(negedge CLK);
        $display("test_reset done");
    endtask

    task automatic test_nominal_n4();
        logic [6:0] got, exp;
        set_defaults();
        run_row(4, 40);
        for (int c = 0; c < 18; c++) begin
            exp = {c == 1, c >= 3 && c <= 6, c >= 7 && c <= 10, c >= 11 && c <= 14,
                   c == 15, c >= 1 && c <= 15, c >= 2 && c <= 13};
            got = {tr_clr[c], tr_mx[c], tr_ac[c], tr_ov[c], tr_done[c], tr_busy[c], tr_rd[c]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL n4_strobes cycle %0d: got clr/max/acc/ov/done/busy/rd=%b required %b",
                         c, got, exp);
            end
            if (exp[0]) begin
                checks++;
                if (int'(tr_addr[c]) !== (c - 2) % 4) begin
                    errors++;
                    $display("FAIL n4_rd_addr cycle %0d: got %0d required %0d", c, tr_addr[c], (c - 2) % 4);
                end
            end
            if (exp[3]) begin
                checks++;
                if (int'(tr_idx[c]) !== c - 11) begin
                    errors++;
                    $display("FAIL n4_out_idx cycle %0d: got %0d required %0d", c, tr_idx[c], c - 11);
                end
            end
        end
        $display("test_nominal_n4 done");
    endtask

    task automatic test_backpressure_n3();
        set_defaults();
        rdy_pat[10] = 1'b0;
        rdy_pat[11] = 1'b0;
        run_row(3, 40);
        for (int c = 10; c <= 12; c++) begin
            checks++;
            if (tr_ov[c] !== 1'b1 || tr_idx[c] !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got ov=%b idx=%0d required ov=1 idx=1", c, tr_ov[c], tr_idx[c]);
            end
        end
        checks++;
        if ({tr_rd[10], tr_rd[11], tr_rd[12]} !== 3'b001 || tr_addr[12] !== 8'd2) begin
            errors++;
            $display("FAIL bp_read: got rd(10..12)=%b addr12=%0d required 001 addr12=2",
                     {tr_rd[10], tr_rd[11], tr_rd[12]}, tr_addr[12]);
        end
        checks++;
        if ({tr_done[12], tr_done[13], tr_done[14]} !== 3'b001) begin
            errors++;
            $display("FAIL bp_done: got done(12..14)=%b required 001", {tr_done[12], tr_done[13], tr_done[14]});
        end
        $display("test_backpressure_n3 done");
    endtask

    task automatic test_zero_len();
        int strobes;
        set_defaults();
        run_row(0, 12);
        strobes = 0;
        for (int c = 0; c < ncyc; c++) strobes += int'(tr_rd[c]) + int'(tr_mx[c]) + int'(tr_ac[c]) + int'(tr_clr[c]);
        checks++;
        if ({tr_done[1], tr_busy[1], tr_busy[2], tr_done[2]} !== 4'b1100) begin
            errors++;
            $display("FAIL zero_done_busy: got done1/busy1/busy2/done2=%b required 1100",
                     {tr_done[1], tr_busy[1], tr_busy[2], tr_done[2]});
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL zero_no_strobes: got %0d strobe cycles required 0", strobes);
        end
        $display("test_zero_len done");
    endtask

    task automatic test_abort();
        int dones;
        set_defaults();
        abort_at = 8;
        run_row(5, 25);
        dones = 0;
        for (int c = 0; c < ncyc; c++) dones += int'(tr_done[c]);
        checks++;
        if (tr_ac[8] !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_acc: got en_acc at cycle 8=%b required 1", tr_ac[8]);
        end
        checks++;
        if ({tr_busy[9], tr_rd[9], tr_mx[9], tr_ac[9], tr_ov[9], tr_done[9], tr_clr[9]} !== 7'b0) begin
            errors++;
            $display("FAIL abort_next: got busy/rd/max/acc/ov/done/clr=%b required 0000000",
                     {tr_busy[9], tr_rd[9], tr_mx[9], tr_ac[9], tr_ov[9], tr_done[9], tr_clr[9]});
        end
        checks++;
        if (dones !== 0 || tr_busy[20] !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses busy20=%b required 0 0", dones, tr_busy[20]);
        end
        set_defaults();
        run_row(2, 20);
        checks++;
        if ({tr_done[8], tr_done[9], tr_busy[9], tr_busy[10]} !== 4'b0110) begin
            errors++;
            $display("FAIL abort_restart: got done8/done9/busy9/busy10=%b required 0110",
                     {tr_done[8], tr_done[9], tr_busy[9], tr_busy[10]});
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_midrow_and_busy_start();
        int accs, outs, dones;
        set_defaults();
        xs_at  = 5;
        xs_len = 8'd7;
        run_row(4, 40);
        accs = 0;
        outs = 0;
        for (int c = 0; c < ncyc; c++) begin
            accs += int'(tr_ac[c]);
            outs += int'(tr_ov[c]);
        end
        checks++;
        if (tr_done[15] !== 1'b1 || accs !== 4 || outs !== 4) begin
            errors++;
            $display("FAIL busy_start_ignored: got done15=%b acc=%0d outs=%0d required 1 4 4", tr_done[15], accs, outs);
        end
        set_defaults();
        rst_at = 12;
        run_row(4, 30);
        dones = 0;
        for (int c = 0; c < ncyc; c++) dones += int'(tr_done[c]);
        checks++;
        if (tr_ov[12] !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_norm: got out_valid at cycle 12=%b required 1", tr_ov[12]);
        end
        checks++;
        if ({tr_busy[13], tr_done[13], tr_rd[13], tr_clr[13], tr_mx[13], tr_ac[13], tr_ov[13]} !== 7'b0 ||
            tr_addr[13] !== 8'd0 || tr_idx[13] !== 8'd0 || dones !== 0) begin
            errors++;
            $display("FAIL rst_midrow: got strobes=%b addr=%0d idx=%0d dones=%0d required 0 0 0 0",
                     {tr_busy[13], tr_done[13], tr_rd[13], tr_clr[13], tr_mx[13], tr_ac[13], tr_ov[13]},
                     tr_addr[13], tr_idx[13], dones);
        end
        $display("test_reset_midrow_and_busy_start done");
    endtask

    task automatic test_max_len();
        int reads, outs, max_addr;
        set_defaults();
        run_row(255, 800);
        reads = 0;
        outs = 0;
        max_addr = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (tr_rd[c]) begin
                reads++;
                if (int'(tr_addr[c]) > max_addr) max_addr = int'(tr_addr[c]);
            end
            if (tr_ov[c] && rdy_pat[c]) outs++;
        end
        checks++;
        if (reads !== 765 || max_addr !== 254 || tr_addr[256] !== 8'd254 || tr_addr[511] !== 8'd254 ||
            tr_addr[766] !== 8'd254) begin
            errors++;
            $display("FAIL max_reads: got reads=%0d max_addr=%0d pass ends=%0d/%0d/%0d required 765 254 254/254/254",
                     reads, max_addr, tr_addr[256], tr_addr[511], tr_addr[766]);
        end
        checks++;
        if (outs !== 255 || tr_done[768] !== 1'b1) begin
            errors++;
            $display("FAIL max_outputs: got outs=%0d done768=%b required 255 1", outs, tr_done[768]);
        end
        $display("test_max_len done");
    endtask

    task automatic test_random_rows();
        int n, c, done_e;
        logic [6:0] got, exp;
        for (int r = 0; r < 8; r++) begin
            set_defaults();
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < MAXC; i++) rdy_pat[i] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < MAXC; i++) begin
                e_bz[i] = 0; e_dn[i] = 0; e_rd[i] = 0; e_cl[i] = 0; e_mx[i] = 0;
                e_ac[i] = 0; e_ov[i] = 0; e_addr[i] = 0; e_idx[i] = 0;
            end
            e_cl[1] = 1;
            for (int k = 0; k < n; k++) begin
                e_rd[2 + k] = 1;     e_addr[2 + k] = k;     e_mx[3 + k] = 1;
                e_rd[n + 2 + k] = 1; e_addr[n + 2 + k] = k; e_ac[n + 3 + k] = 1;
            end
            // Element k is presented until the first ready cycle; that cycle also reads k+1.
            e_rd[2 * n + 2] = 1;
            e_addr[2 * n + 2] = 0;
            c = 2 * n + 3;
            for (int k = 0; k < n; k++) begin
                while (!rdy_pat[c]) begin
                    e_ov[c] = 1; e_idx[c] = k; c++;
                end
                e_ov[c] = 1;
                e_idx[c] = k;
                if (k < n - 1) begin
                    e_rd[c] = 1;
                    e_addr[c] = k + 1;
                end
                c++;
            end
            done_e = c;
            e_dn[done_e] = 1;
            for (int i = 1; i <= done_e; i++) e_bz[i] = 1;
            run_row(n, MAXC - 1);
            for (int i = 0; i <= done_e + 1; i++) begin
                exp = {e_cl[i], e_mx[i], e_ac[i], e_ov[i], e_dn[i], e_bz[i], e_rd[i]};
                got = {tr_clr[i], tr_mx[i], tr_ac[i], tr_ov[i], tr_done[i], tr_busy[i], tr_rd[i]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand_strobes row %0d N=%0d cycle %0d: got clr/max/acc/ov/done/busy/rd=%b required %b",
                             r, n, i, got, exp);
                end
                if (e_rd[i] && int'(tr_addr[i]) !== e_addr[i]) begin
                    errors++;
                    $display("FAIL rand_rd_addr row %0d cycle %0d: got %0d required %0d", r, i, tr_addr[i], e_addr[i]);
                end
                if (e_ov[i] && int'(tr_idx[i]) !== e_idx[i]) begin
                    errors++;
                    $display("FAIL rand_out_idx row %0d cycle %0d: got %0d required %0d", r, i, tr_idx[i], e_idx[i]);
                end
            end
            $display("test_random_rows row %0d N=%0d expected done cycle %0d", r, n, done_e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_defaults();
        test_reset();
        test_nominal_n4();
        test_backpressure_n3();
        test_zero_len();
        test_abort();
        test_reset_midrow_and_busy_start();
        test_max_len();
        test_random_rows();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
